// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    // Controller states: normal issue, waiting on a data-memory access,
    // and the terminal timeout state.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    // Register 0 is hard-wired to zero, so a load targeting it never creates
    // a real dependency.
    localparam int REG_ZERO = 0;

    // All-ones source for the saturating stall counter; the controller keeps
    // the low CNT_W bits as its ceiling (CNT_W up to 64).
    localparam int SAT_MAX_W = 64;
    localparam logic [SAT_MAX_W-1:0] SAT_ALL_ONES = '1;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls grouped as one bundle.
// slave is the controller side, master is the pipeline/environment side.
interface pipeline_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs_i;
    logic [REG_ADDR_W-1:0] id_rt_i;
    logic                  id_uses_rt_i;
    logic [REG_ADDR_W-1:0] ex_rd_i;
    logic                  ex_mem_read_i;
    logic                  mem_branch_taken_i;
    logic                  mem_access_i;
    logic                  dmem_ready_i;

    logic                  dmem_req_o;
    logic                  pc_write_o;
    logic                  if_id_write_o;
    logic                  if_id_flush_o;
    logic                  id_ex_write_o;
    logic                  id_ex_flush_o;
    logic                  ex_mem_write_o;
    logic                  ex_mem_flush_o;
    logic                  mem_wb_flush_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic                  error_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_rd_i, ex_mem_read_i,
               mem_branch_taken_i, mem_access_i, dmem_ready_i,
        input  dmem_req_o, pc_write_o, if_id_write_o, if_id_flush_o,
               id_ex_write_o, id_ex_flush_o, ex_mem_write_o, ex_mem_flush_o,
               mem_wb_flush_o, stall_cnt_o, error_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_rd_i, ex_mem_read_i,
               mem_branch_taken_i, mem_access_i, dmem_ready_i,
        output dmem_req_o, pc_write_o, if_id_write_o, if_id_flush_o,
               id_ex_write_o, id_ex_flush_o, ex_mem_write_o, ex_mem_flush_o,
               mem_wb_flush_o, stall_cnt_o, error_o
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: the instruction in EX is a load whose destination is
// read by the instruction in ID. Purely combinational.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    logic rd_live;
    logic rs_hit;
    logic rt_hit;

    assign rd_live  = (ex_rd != REG_ADDR_W'(REG_ZERO));
    assign rs_hit   = (ex_rd == id_rs);
    assign rt_hit   = id_uses_rt && (ex_rd == id_rt);
    assign load_use = ex_mem_read && rd_live && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: sequences
// multi-cycle data-memory accesses, resolves branch and load-use hazards,
// counts stalled cycles and latches a memory-timeout error.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 16,
    parameter int CNT_W      = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pipeline_ctrl_if.slave  bus
);

    localparam int               WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = SAT_ALL_ONES[CNT_W-1:0];

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              load_use;
    logic              freeze;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_rs       (bus.id_rs_i),
        .id_rt       (bus.id_rt_i),
        .id_uses_rt  (bus.id_uses_rt_i),
        .ex_rd       (bus.ex_rd_i),
        .ex_mem_read (bus.ex_mem_read_i),
        .load_use    (load_use)
    );

    // State and wait counter; reset drops straight back to RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Stall counter: counts cycles with the PC held, sticking at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!bus.pc_write_o && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Next state plus all pipeline controls. A freeze holds every stage and
    // bubbles MEM/WB; otherwise branch beats load-use, which beats normal flow.
    always_comb begin
        state_nxt          = state;
        wait_nxt           = wait_cnt;
        freeze             = 1'b0;
        bus.dmem_req_o     = bus.mem_access_i;
        bus.pc_write_o     = 1'b1;
        bus.if_id_write_o  = 1'b1;
        bus.if_id_flush_o  = 1'b0;
        bus.id_ex_write_o  = 1'b1;
        bus.id_ex_flush_o  = 1'b0;
        bus.ex_mem_write_o = 1'b1;
        bus.ex_mem_flush_o = 1'b0;
        bus.mem_wb_flush_o = 1'b0;

        case (state)
            RUN: begin
                if (bus.mem_access_i && !bus.dmem_ready_i) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready_i) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt < WAIT_W'(MAX_WAIT)) begin
                    freeze   = 1'b1;
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end else begin
                    freeze    = 1'b1;
                    state_nxt = ERROR;
                end
            end
            default: begin
                freeze         = 1'b1;
                bus.dmem_req_o = 1'b0;
            end
        endcase

        if (freeze) begin
            bus.pc_write_o     = 1'b0;
            bus.if_id_write_o  = 1'b0;
            bus.id_ex_write_o  = 1'b0;
            bus.ex_mem_write_o = 1'b0;
            bus.mem_wb_flush_o = 1'b1;
        end else if (bus.mem_branch_taken_i) begin
            bus.if_id_flush_o  = 1'b1;
            bus.id_ex_flush_o  = 1'b1;
            bus.ex_mem_flush_o = 1'b1;
        end else if (load_use) begin
            bus.pc_write_o     = 1'b0;
            bus.if_id_write_o  = 1'b0;
            bus.id_ex_flush_o  = 1'b1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.error_o     = (state == ERROR);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios plus random traffic,
// checked against a behavioural model of the stall/flush rules.
module tb_pipeline_ctrl;

    localparam int RW = 5;
    localparam int MW = 16;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    // Control vector order: req, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_f
    localparam logic [8:0] V_NORMAL = 9'b0_1101_0100;

    typedef struct packed {
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          ut;
        logic [RW-1:0] rd;
        logic          mr;
        logic          br;
        logic          ma;
        logic          rdy;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    int   m_waits;
    bit   m_dead;
    int   m_stall;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    pipeline_ctrl #(
        .REG_ADDR_W (RW),
        .MAX_WAIT   (MW),
        .CNT_W      (CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic stim_t mk(int rs, int rt, bit ut, int rd, bit mr, bit br, bit ma, bit rdy);
        stim_t s;
        s.rs = RW'(rs); s.rt = RW'(rt); s.ut = ut; s.rd = RW'(rd);
        s.mr = mr; s.br = br; s.ma = ma; s.rdy = rdy;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.id_rs_i            = s.rs;
        bus.id_rt_i            = s.rt;
        bus.id_uses_rt_i       = s.ut;
        bus.ex_rd_i            = s.rd;
        bus.ex_mem_read_i      = s.mr;
        bus.mem_branch_taken_i = s.br;
        bus.mem_access_i       = s.ma;
        bus.dmem_ready_i       = s.rdy;
    endtask

    function automatic logic [8:0] obs_vec();
        return {bus.dmem_req_o, bus.pc_write_o, bus.if_id_write_o, bus.if_id_flush_o,
                bus.id_ex_write_o, bus.id_ex_flush_o, bus.ex_mem_write_o,
                bus.ex_mem_flush_o, bus.mem_wb_flush_o};
    endfunction

    // Expected controls from the rules: timeout freezes forever, an
    // unfinished memory access freezes, then branch, then load-use.
    function automatic logic [8:0] model_out();
        bit lu;
        bit mem_stall;
        bit ma;
        ma = bus.mem_access_i;
        lu = bus.ex_mem_read_i && (bus.ex_rd_i != 0) &&
             ((bus.ex_rd_i == bus.id_rs_i) || (bus.id_uses_rt_i && (bus.ex_rd_i == bus.id_rt_i)));
        if (m_dead) return 9'b0_0000_0001;
        mem_stall = (m_waits > 0) ? !bus.dmem_ready_i : (ma && !bus.dmem_ready_i);
        if (mem_stall) return {ma, 8'b0000_0001};
        if (bus.mem_branch_taken_i) return {ma, 8'b1111_1110};
        if (lu) return {ma, 8'b0001_1100};
        return {ma, 8'b1101_0100};
    endfunction

    // Advance the model across one rising edge given this cycle's controls.
    task automatic model_tick(input logic [8:0] o);
        if (!o[7] && m_stall < SAT) m_stall++;
        if (!m_dead) begin
            if (o[0]) begin
                if (m_waits == 0) m_waits = 1;
                else if (m_waits < MW) m_waits++;
                else m_dead = 1;
            end else begin
                m_waits = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_waits = 0;
        m_dead  = 0;
        m_stall = 0;
    endtask

    task automatic do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #2;
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        model_tick(model_out());
        #1;
    endtask

    task automatic test_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        model_reset();
        #2;
        vectors++;
        if (obs_vec() !== V_NORMAL || bus.stall_cnt_o !== '0 || bus.error_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got ctrl=%b stall=%0d err=%b, want ctrl=%b stall=0 err=0",
                     obs_vec(), bus.stall_cnt_o, bus.error_o, V_NORMAL);
        end
        rst = 1'b0;
        @(posedge clk);
        model_tick(model_out());
        #1;
    endtask

    task automatic test_load_use();
        stim_t tbl[5];
        logic [8:0] exp;
        do_reset();
        tbl[0] = mk(5, 0, 0, 5, 1, 0, 0, 0);  // rs match
        tbl[1] = mk(7, 0, 0, 9, 0, 0, 0, 0);  // load now in MEM
        tbl[2] = mk(1, 6, 1, 6, 1, 0, 0, 0);  // rt match, rt used
        tbl[3] = mk(1, 6, 0, 6, 1, 0, 0, 0);  // rt match, rt unused
        tbl[4] = mk(3, 3, 1, 3, 0, 0, 0, 0);  // not a load
        for (int i = 0; i < 5; i++) begin
            apply(tbl[i]);
            @(negedge clk);
            exp = model_out();
            vectors++;
            if (obs_vec() !== exp || bus.stall_cnt_o !== CW'(m_stall) || bus.error_o !== m_dead) begin
                miscompares++;
                $display("FAIL load_use[%0d]: got ctrl=%b stall=%0d err=%b, want ctrl=%b stall=%0d err=%b",
                         i, obs_vec(), bus.stall_cnt_o, bus.error_o, exp, m_stall, m_dead);
            end
            @(posedge clk);
            model_tick(exp);
            #1;
            if (i == 1) begin
                vectors++;
                if (bus.stall_cnt_o !== CW'(1)) begin
                    miscompares++;
                    $display("FAIL load_use_cnt: got stall=%0d, want 1", bus.stall_cnt_o);
                end
            end
        end
    endtask

    task automatic test_reg_zero();
        do_reset();
        apply(mk(0, 0, 1, 0, 1, 0, 0, 0));
        @(negedge clk);
        vectors++;
        if (obs_vec() !== V_NORMAL) begin
            miscompares++;
            $display("FAIL reg_zero: got ctrl=%b, want ctrl=%b", obs_vec(), V_NORMAL);
        end
        @(posedge clk);
        model_tick(model_out());
        #1;
        vectors++;
        if (bus.stall_cnt_o !== '0) begin
            miscompares++;
            $display("FAIL reg_zero_cnt: got stall=%0d, want 0", bus.stall_cnt_o);
        end
    endtask

    task automatic test_branch_override();
        do_reset();
        apply(mk(5, 0, 0, 5, 1, 1, 0, 0));
        @(negedge clk);
        vectors++;
        if (obs_vec() !== 9'b0_1111_1110) begin
            miscompares++;
            $display("FAIL branch_override: got ctrl=%b, want ctrl=%b", obs_vec(), 9'b0_1111_1110);
        end
        @(posedge clk);
        model_tick(model_out());
        #1;
        vectors++;
        if (bus.stall_cnt_o !== '0) begin
            miscompares++;
            $display("FAIL branch_cnt: got stall=%0d, want 0", bus.stall_cnt_o);
        end
    endtask

    task automatic test_mem_wait();
        stim_t tbl[7];
        logic [8:0] exp;
        do_reset();
        tbl[0] = mk(0, 0, 0, 0, 0, 0, 1, 0);
        tbl[1] = mk(0, 0, 0, 0, 0, 0, 1, 0);
        tbl[2] = mk(0, 0, 0, 0, 0, 0, 1, 1);  // ready on the 3rd cycle
        tbl[3] = mk(0, 0, 0, 0, 0, 0, 1, 1);  // completes in request cycle
        tbl[4] = mk(0, 0, 0, 0, 0, 0, 1, 0);
        tbl[5] = mk(4, 0, 0, 4, 1, 0, 1, 1);  // completes with load-use pending
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i]);
            @(negedge clk);
            exp = model_out();
            vectors++;
            if (obs_vec() !== exp || bus.stall_cnt_o !== CW'(m_stall) || bus.error_o !== m_dead) begin
                miscompares++;
                $display("FAIL mem_wait[%0d]: got ctrl=%b stall=%0d err=%b, want ctrl=%b stall=%0d err=%b",
                         i, obs_vec(), bus.stall_cnt_o, bus.error_o, exp, m_stall, m_dead);
            end
            @(posedge clk);
            model_tick(exp);
            #1;
            if (i == 3) begin
                vectors++;
                if (bus.stall_cnt_o !== CW'(2)) begin
                    miscompares++;
                    $display("FAIL mem_wait_cnt: got stall=%0d, want 2", bus.stall_cnt_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [8:0] exp;
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            model_tick(model_out());
        end
        #1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        exp = model_out();
        vectors++;
        if (obs_vec() !== exp || exp !== 9'b0_0000_0001) begin
            miscompares++;
            $display("FAIL mid_wait_hold: got ctrl=%b, want ctrl=%b", obs_vec(), 9'b0_0000_0001);
        end
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (obs_vec() !== V_NORMAL || bus.stall_cnt_o !== '0) begin
            miscompares++;
            $display("FAIL mid_wait_rst: got ctrl=%b stall=%0d, want ctrl=%b stall=0",
                     obs_vec(), bus.stall_cnt_o, V_NORMAL);
        end
        rst = 1'b0;
        @(posedge clk);
        model_tick(model_out());
        #1;
    endtask

    task automatic test_timeout();
        logic [8:0] exp;
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            exp = model_out();
            vectors++;
            if (obs_vec() !== exp || bus.stall_cnt_o !== CW'(m_stall) || bus.error_o !== m_dead) begin
                miscompares++;
                $display("FAIL timeout[%0d]: got ctrl=%b stall=%0d err=%b, want ctrl=%b stall=%0d err=%b",
                         i, obs_vec(), bus.stall_cnt_o, bus.error_o, exp, m_stall, m_dead);
            end
            @(posedge clk);
            model_tick(exp);
        end
        @(negedge clk);
        vectors++;
        if (bus.error_o !== 1'b1 || bus.dmem_req_o !== 1'b0 || bus.stall_cnt_o !== CW'(SAT)) begin
            miscompares++;
            $display("FAIL timeout_err: got err=%b req=%b stall=%0d, want err=1 req=0 stall=%0d",
                     bus.error_o, bus.dmem_req_o, bus.stall_cnt_o, SAT);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (bus.error_o !== 1'b0 || bus.stall_cnt_o !== '0 || bus.dmem_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_rst: got err=%b stall=%0d req=%b, want err=0 stall=0 req=1",
                     bus.error_o, bus.stall_cnt_o, bus.dmem_req_o);
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        @(posedge clk);
        model_tick(model_out());
        #1;
    endtask

    task automatic test_saturation();
        logic [8:0] exp;
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            exp = model_out();
            vectors++;
            if (obs_vec() !== exp || bus.stall_cnt_o !== CW'(m_stall) || bus.error_o !== m_dead) begin
                miscompares++;
                $display("FAIL saturate[%0d]: got ctrl=%b stall=%0d err=%b, want ctrl=%b stall=%0d err=%b",
                         i, obs_vec(), bus.stall_cnt_o, bus.error_o, exp, m_stall, m_dead);
            end
            @(posedge clk);
            model_tick(exp);
        end
        #1;
        vectors++;
        if (bus.stall_cnt_o !== CW'(SAT)) begin
            miscompares++;
            $display("FAIL saturate_cnt: got stall=%0d, want %0d", bus.stall_cnt_o, SAT);
        end
    endtask

    task automatic test_random();
        logic [8:0] exp;
        stim_t s;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_dead && ($urandom_range(0, 3) == 0)) do_reset();
            s = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
            apply(s);
            @(negedge clk);
            exp = model_out();
            vectors++;
            if (obs_vec() !== exp || bus.stall_cnt_o !== CW'(m_stall) || bus.error_o !== m_dead) begin
                miscompares++;
                $display("FAIL random[%0d]: got ctrl=%b stall=%0d err=%b, want ctrl=%b stall=%0d err=%b",
                         i, obs_vec(), bus.stall_cnt_o, bus.error_o, exp, m_stall, m_dead);
            end
            @(posedge clk);
            model_tick(exp);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_reg_zero();
        test_branch_override();
        test_mem_wait();
        test_reset_mid_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage pipeline. It watches ID/EX/MEM stage hazard information and the data-memory handshake. It drives write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences multi-cycle data-memory accesses, counts stall cycles and flags a memory-timeout error.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width
- MAX_WAIT, 16, maximum MEM_WAIT cycles before timeout (≥2)
- CNT_W, 32, stall counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- id_rs_i  in  REG_ADDR_W  rs of instruction in ID
- id_rt_i  in  REG_ADDR_W  rt of instruction in ID
- id_uses_rt_i  in  1  ID instruction reads rt
- ex_rd_i  in  REG_ADDR_W  destination of instruction in EX
- ex_mem_read_i  in  1  EX instruction is a load
- mem_branch_taken_i  in  1  branch in MEM resolved taken
- mem_access_i  in  1  MEM instruction is load or store
- dmem_ready_i  in  1  data memory completes access this cycle
- dmem_req_o  out  1  data-memory request
- pc_write_o  out  1  PC load enable
- if_id_write_o  out  1  IF/ID load enable
- if_id_flush_o  out  1  IF/ID load bubble
- id_ex_write_o  out  1  ID/EX load enable
- id_ex_flush_o  out  1  ID/EX load bubble (control bits zero)
- ex_mem_write_o  out  1  EX/MEM load enable
- ex_mem_flush_o  out  1  EX/MEM load bubble
- mem_wb_flush_o  out  1  MEM/WB load bubble
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0, saturating
- error_o  out  1  memory timeout, sticky

## Operation
- States: RUN, MEM_WAIT, ERROR. Reset → RUN, wait_cnt=0, stall_cnt=0, error_o=0.
- Freeze means: pc_write, if_id_write, id_ex_write and ex_mem_write are 0; mem_wb_flush is 1; all other flushes are 0.
- Normal means: all writes are 1 and all flushes are 0.
- RUN, mem_access_i=1, dmem_ready_i=0: freeze and go to MEM_WAIT with wait_cnt=1.
- RUN, mem_access_i=0, or mem_access_i=1 with dmem_ready_i=1: no memory stall; apply the rules below in priority order.
  - Branch: mem_branch_taken_i=1 → normal writes, plus if_id_flush, id_ex_flush and ex_mem_flush all 1. PC loads the target.
  - Load-use, when no branch: ex_mem_read_i=1 and ex_rd_i≠0 and (ex_rd_i==id_rs_i or (id_uses_rt_i and ex_rd_i==id_rt_i)) → pc_write=0, if_id_write=0, id_ex_flush=1. ex_mem_write=1 and mem_wb_flush=0.
  - Otherwise normal.
- MEM_WAIT:
  - dmem_ready_i=1 → outputs equal the RUN evaluation with the memory stall removed (branch/load-use rules apply), then go to RUN with wait_cnt=0.
  - dmem_ready_i=0 with wait_cnt<MAX_WAIT → freeze, wait_cnt+1.
  - dmem_ready_i=0 with wait_cnt==MAX_WAIT → freeze, go to ERROR.
- ERROR: freeze permanently, dmem_req_o=0, error_o=1. Only rst_i exits.
- dmem_req_o = mem_access_i in RUN and MEM_WAIT.
- A load-use stall to register 0 never occurs. A branch always overrides a simultaneous load-use.
- stall_cnt increments each cycle pc_write_o=0 and stops at all-ones.

## Timing
- All control outputs are combinational from state and current inputs, valid in the same cycle. There is no added latency.
- State, wait_cnt, stall_cnt and error_o are registered; they update on the rising clk_i edge.
- An access that completes in the request cycle costs 0 stall cycles. An access with ready at cycle N after the request costs N freeze cycles.
- rst_i asserted mid-MEM_WAIT forces RUN immediately (asynchronous) and clears the counters. Outputs then reflect RUN evaluation of the current inputs.
- The load-use stall lasts exactly 1 cycle: the next cycle the load is in MEM and the inputs no longer match.

## Structure
- Package pipeline_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, ERROR}
  - REG_ZERO constant
  - localparam for the saturating-count maximum
- Sub-module hazard_detect is purely combinational: rs/rt/rd compare producing load_use. It is instantiated once.
- The FSM, wait counter and stall counter live in pipeline_ctrl.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0→1; normal next cycle.
- ex_rd=0, ex_mem_read=1, id_rs=0 → no stall, all writes 1.
- Branch plus load-use in the same cycle → pc_write=1, three flushes=1, stall_cnt unchanged.
- mem_access=1, ready at the 3rd cycle → 2 freeze cycles with mem_wb_flush=1 and dmem_req=1, advance on the 3rd cycle, stall_cnt=2.
- mem_access=1, ready never (MAX_WAIT=16) → error_o=1 after 17 freeze cycles, dmem_req=0. Asserting rst_i clears error_o asynchronously and stall_cnt=0.
- Force stall_cnt near all-ones (CNT_W=4) → saturates at 15.
